// File: rtl/aes_mode_pkg.sv
// Shared types and constants for the AES block-cipher mode engine.
package aes_mode_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    MODE_ECB = 2'b00,
    MODE_CBC = 2'b01,
    MODE_CTR = 2'b10,
    MODE_OFB = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    UNCFG,
    READY,
    START,
    WAIT,
    OUT
  } state_e;

endpackage

// File: rtl/aes_mode_engine_if.sv
// Valid/ready block stream between the host DMA (master) and the mode engine (slave).
interface aes_mode_engine_if;
  import aes_mode_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/aes_mode_engine_core.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion.
// start loads key/pt; done pulses for one cycle with ct valid ten cycles later.
module aes_mode_engine_core
  import aes_mode_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] key,
  input  logic [AES_BLK_W-1:0] pt,
  output logic                 done,
  output logic [AES_BLK_W-1:0] ct
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [AES_BLK_W-1:0] next_key(input logic [AES_BLK_W-1:0] k,
                                                    input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, tmp;
    {w0, w1, w2, w3} = k;
    tmp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ tmp;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [AES_BLK_W-1:0] aes_round(input logic [AES_BLK_W-1:0] s,
                                                     input logic [AES_BLK_W-1:0] rk,
                                                     input logic                 last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [AES_BLK_W-1:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = b[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res ^ rk;
  endfunction

  logic [AES_BLK_W-1:0] blk_q;
  logic [AES_BLK_W-1:0] rk_q;
  logic [AES_BLK_W-1:0] rk_next;
  logic [7:0]           rcon_q;
  logic [3:0]           round_q;
  logic                 run_q;
  logic                 done_q;

  assign rk_next = next_key(rk_q, rcon_q);

  // NOTE: every register here uses <= so all of them see the pre-edge values of one another.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q   <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
      round_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        blk_q   <= pt ^ key;
        rk_q    <= key;
        rcon_q  <= 8'h01;
        round_q <= 4'd1;
        run_q   <= 1'b1;
      end else if (run_q) begin
        blk_q   <= aes_round(blk_q, rk_next, round_q == 4'd10);
        rk_q    <= rk_next;
        rcon_q  <= xtime(rcon_q);
        round_q <= round_q + 4'd1;
        if (round_q == 4'd10) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign ct   = blk_q;

endmodule

// File: rtl/aes_mode_engine.sv
// ECB / CBC-encrypt / CTR stream mode engine around the iterative AES core.
// Optional OFB mode (cfg_mode 11) is compiled in with `define AES_MODE_OFB_EN.
module aes_mode_engine
  import aes_mode_pkg::*;
#(
  parameter int CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_load,
  input  logic [1:0]           cfg_mode,
  input  logic [AES_BLK_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  output logic                 cfg_err,
  aes_mode_engine_if.slave     stream,
  output logic                 busy,
  output logic [AES_BLK_W-1:0] chain_q
);

  localparam logic [AES_BLK_W-1:0] CTR_MASK = (CTR_WIDTH >= AES_BLK_W) ? {AES_BLK_W{1'b1}} :
    ((AES_BLK_W'(1) << CTR_WIDTH) - AES_BLK_W'(1));

  state_e               state_q, state_d;
  mode_e                mode_q;
  logic [AES_BLK_W-1:0] key_q, iv_q, data_q, core_in_q, out_data_q;
  logic [AES_BLK_W-1:0] core_in_d, core_ct, ctr_next;
  logic                 last_q, out_last_q, cfg_err_q;
  logic                 mode_ok, cfg_accept, in_fire, out_fire;
  logic                 core_start, core_done, core_rst;

`ifdef AES_MODE_OFB_EN
  assign mode_ok = 1'b1;
`else
  assign mode_ok = (mode_e'(cfg_mode) != MODE_OFB);
`endif

  // A pending cfg_load blocks acceptance so the next block always sees the new config.
  assign cfg_accept      = cfg_load && (state_q == UNCFG || state_q == READY);
  assign stream.in_ready = (state_q == READY) && !cfg_load;
  assign in_fire         = stream.in_valid && stream.in_ready;
  assign stream.out_valid = (state_q == OUT);
  assign out_fire        = stream.out_valid && stream.out_ready;
  assign stream.out_data = out_data_q;
  assign stream.out_last = out_last_q;
  assign busy            = (state_q == START) || (state_q == WAIT) || (state_q == OUT);
  assign cfg_err         = cfg_err_q;
  assign core_start      = (state_q == START);
  assign core_rst        = ~rst_n;

  // Low CTR_WIDTH bits wrap modulo 2^CTR_WIDTH; the carry out is masked off.
  assign ctr_next = ((chain_q + {{(AES_BLK_W-1){1'b0}}, 1'b1}) & CTR_MASK) |
                    (chain_q & ~CTR_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= UNCFG;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNCFG: if (cfg_load) state_d = mode_ok ? READY : UNCFG;
      READY: begin
        if (cfg_load)     state_d = mode_ok ? READY : UNCFG;
        else if (in_fire) state_d = START;
      end
      START: state_d = WAIT;
      WAIT:  if (core_done) state_d = OUT;
      OUT:   if (out_fire) state_d = READY;
      default: state_d = UNCFG;
    endcase
  end

  always_comb begin
    core_in_d = stream.in_data;
    case (mode_q)
      MODE_CBC:           core_in_d = stream.in_data ^ chain_q;
      MODE_CTR, MODE_OFB: core_in_d = chain_q;
      default:            core_in_d = stream.in_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_ECB;
      key_q      <= '0;
      iv_q       <= '0;
      chain_q    <= '0;
      data_q     <= '0;
      core_in_q  <= '0;
      out_data_q <= '0;
      last_q     <= 1'b0;
      out_last_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (cfg_accept) begin
        if (mode_ok) begin
          mode_q    <= mode_e'(cfg_mode);
          key_q     <= cfg_key;
          iv_q      <= cfg_iv;
          chain_q   <= cfg_iv;
          cfg_err_q <= 1'b0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (in_fire) begin
        data_q    <= stream.in_data;
        last_q    <= stream.in_last;
        core_in_q <= core_in_d;
      end
      if (state_q == WAIT && core_done) begin
        out_last_q <= last_q;
        case (mode_q)
          MODE_ECB: out_data_q <= core_ct;
          MODE_CBC: begin
            out_data_q <= core_ct;
            chain_q    <= core_ct;
          end
          MODE_CTR: begin
            out_data_q <= core_ct ^ data_q;
            chain_q    <= ctr_next;
          end
          default: begin
            out_data_q <= core_ct ^ data_q;
            chain_q    <= core_ct;
          end
        endcase
      end
      // End of message: the next message restarts from the configured IV.
      if (out_fire && out_last_q) chain_q <= iv_q;
    end
  end

  aes_mode_engine_core u_core (
    .clk   (clk),
    .rst   (core_rst),
    .start (core_start),
    .key   (key_q),
    .pt    (core_in_q),
    .done  (core_done),
    .ct    (core_ct)
  );

endmodule

// File: doc/aes_mode_engine.md
Name: aes_mode_engine

Overview:
- Streaming block-cipher mode engine wrapped around the existing iterative AES_Core, which encrypts one AES-128 block per start/done transaction.
- Adds ECB, CBC-encrypt and CTR modes, plus optional OFB, a valid/ready stream interface, a 128-bit chaining/counter register and message framing via last.
- Sits between the host DMA stream and the AES core.

Parameters:
- CTR_WIDTH, 32, number of low-order bits of the counter block incremented in CTR mode (1..128).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cfg_load  input  1  single-cycle pulse: latch cfg_mode/cfg_key/cfg_iv
- cfg_mode  input  2  00 ECB, 01 CBC-enc, 10 CTR, 11 OFB (optional)
- cfg_key  input  128  cipher key
- cfg_iv  input  128  IV / initial counter block
- cfg_err  output  1  unsupported mode latched
- in_valid  input  1  input block valid
- in_ready  output  1  engine accepts a block
- in_data  input  128  plaintext block
- in_last  input  1  final block of message
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_data  output  128  result block
- out_last  output  1  echoes in_last of this block
- busy  output  1  high in START/WAIT/OUT
- chain_q  output  128  current chaining/counter register

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, cfg_err=0, busy=0, chain_q=0; state UNCFG.
- The core's active-high rst is driven from ~rst_n.
- States:
  - UNCFG: in_ready=0. Valid cfg_load goes to READY.
  - READY: in_ready=1. On in_valid&in_ready, capture in_data/in_last and form the core input:
    - ECB: data.
    - CBC: data^chain.
    - CTR and OFB: chain.
    - Then go to START.
  - START: one-cycle core start pulse, then WAIT.
  - WAIT: hold until core done. Register the result:
    - ECB and CBC: ct.
    - CTR and OFB: ct^data.
    - Chain update: CBC gets ct; CTR increments the low CTR_WIDTH bits modulo 2^CTR_WIDTH with upper bits unchanged; OFB gets ct.
    - Then go to OUT.
  - OUT: out_valid=1 and out_data/out_last held stable until out_ready. On the handshake go to READY. If out_last=1, chain reloads the IV latched at cfg_load (next message restarts).
- Latency: input handshake to out_valid = core latency + 2 clk. Throughput is one block in flight. in_ready=0 outside READY.
- cfg_load is honoured only in UNCFG/READY. It is ignored while busy, with no side effects. It latches key/mode/IV, sets chain=IV and clears cfg_err.
- The key is presented to the core from the latched copy, stable for the whole operation.
- Back-pressure: out_ready low holds OUT indefinitely with data stable. No input is accepted meanwhile.
- Simultaneous cfg_load and in_valid in READY: cfg_load wins, in_ready is forced 0 that cycle, and the block is accepted next cycle using the new config.
- Reset mid-operation: the core and engine return to reset values. A result that has not yet handed over through out_valid/out_ready is discarded.

Optional Feature:
- Macro AES_MODE_OFB_EN.
- Defined: mode 11 = OFB as above.
- Undefined: cfg_load with mode 11 sets cfg_err=1 and goes to UNCFG; in_ready stays 0 until a cfg_load with a supported mode.

Decomposition:
- Package aes_mode_pkg:
  - mode enum: MODE_ECB, MODE_CBC, MODE_CTR, MODE_OFB.
  - state enum: UNCFG, READY, START, WAIT, OUT.
  - block width constant AES_BLK_W=128.
- Sub-module: the AES_Core instance only. Chaining and XOR logic stay in aes_mode_engine.

Test Plan:
- ECB: key 000102030405060708090A0B0C0D0E0F, in_data 00112233445566778899AABBCCDDEEFF -> out_data 69C4E0D86A7B0430D8CDB78070B4C55A; chain_q unchanged.
- CBC: IV 0, same key/data, in_last=0 -> out 69C4E0D8...C55A and chain_q=69C4E0D8...C55A. Then a second block 69C4E0D8...C55A (data^chain=0) -> out equals ECB(0) from the model.
- CTR: IV 00112233445566778899AABBCCDDEEFF, data 0 -> out 69C4E0D8...C55A, chain_q=00112233445566778899AABBCCDDEF00.
- CTR wrap, CTR_WIDTH=32: IV 0102030405060708090A0B0CFFFFFFFF -> chain_q=0102030405060708090A0B0C00000000 after one block. With in_last=1, after the output handshake chain_q returns to the IV.
- Back-pressure: hold out_ready=0 for 20 cycles -> out_valid stays 1, out_data stable, in_ready=0. Then cfg_load during OUT is ignored (chain_q, mode unchanged).
- Without AES_MODE_OFB_EN: cfg_load mode 11 -> cfg_err=1, in_ready=0. rst_n low during WAIT -> all outputs at reset values next cycle.
